// File: rtl/nn_dense_layer_seq_pkg.sv
// Shared types and arithmetic helpers for the sequential dense-layer engine.
package nn_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_DEF   = 16;
  localparam int ACC_W_DEF  = 48;

  // Helpers work on a fixed wide signed value; callers sign-extend in and truncate out.
  localparam int WIDE_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MAC    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FINISH = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  function automatic logic signed [WIDE_W-1:0] relu(input logic signed [WIDE_W-1:0] v);
    return v[WIDE_W-1] ? '0 : v;
  endfunction

  // Clamp to the signed range of a dw-bit result.
  function automatic logic signed [WIDE_W-1:0] sat_q(input logic signed [WIDE_W-1:0] v,
                                                     input int unsigned dw);
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    one = WIDE_W'(1);
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_dense_layer_seq_mac_lane.sv
// One multiply-accumulate lane: registered Q-format product, wrapping accumulator.
module nn_mac_lane #(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [ACC_W-1:0]    prod_q;
  logic                       prod_vld_q;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod    = (2*DATA_W)'(x_i) * (2*DATA_W)'(w_i);
  assign prod_sh = prod >>> FRAC;
  assign acc_o   = acc_q;

  // Product register stage followed by the accumulator (wraps modulo 2^ACC_W).
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_vld_q <= en_i;
      if (en_i) prod_q <= ACC_W'(prod_sh);
      if (clear_i)         acc_q <= '0;
      else if (prod_vld_q) acc_q <= acc_q + prod_q;
    end
  end

endmodule

// File: rtl/nn_dense_layer_seq.sv
// Time-multiplexed dense layer: buffers one input vector, computes LANES neurons
// per group from external weight/bias memories, streams results one per beat.
module nn_dense_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 256,
  parameter int LANES  = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  localparam int G     = (N_OUT + LANES - 1) / LANES,
  localparam int WA_W  = (G * N_IN > 1) ? $clog2(G * N_IN) : 1,
  localparam int BA_W  = (G > 1) ? $clog2(G) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    act_relu,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [WA_W-1:0]         w_addr,
  input  logic [LANES*DATA_W-1:0] w_rdata,
  output logic [BA_W-1:0]         b_addr,
  input  logic [LANES*DATA_W-1:0] b_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last
);

  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAST_L = N_OUT - (G - 1) * LANES;

  state_t            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [BA_W-1:0]   g_q, g_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              fl_q, fl_d;
  logic              relu_q, relu_d;

  logic [DATA_W-1:0] in_buf [N_IN];
  logic [DATA_W-1:0] x_q;
  logic              rd_vld_q;
  logic              clear;
  logic [LW-1:0]     last_lane;
  logic              last_group;

  logic signed [ACC_W-1:0] acc   [LANES];
  logic [DATA_W-1:0]       res_q [LANES];
  logic [DATA_W-1:0]       res_d [LANES];
  logic signed [ACC_W-1:0] sum_c;

  assign last_group = (g_q == BA_W'(G - 1));
  assign last_lane  = last_group ? LW'(LAST_L - 1) : LW'(LANES - 1);

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid && last_group && (lane_q == last_lane);
  assign out_data  = res_q[lane_q];
  assign w_addr    = WA_W'(int'(g_q) * N_IN + int'(i_q));
  assign b_addr    = g_q;

  // Accumulators start from zero on every entry into MAC, including later groups.
  assign clear = (state_q != ST_MAC) && (state_d == ST_MAC);

  // Sequencer: load, multiply-accumulate, flush pipeline, finish, drain per group.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    g_d     = g_q;
    lane_d  = lane_q;
    fl_d    = fl_q;
    relu_d  = relu_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          relu_d  = act_relu;
          g_d     = '0;
          i_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (i_q == IW'(N_IN - 1)) begin
            i_d     = '0;
            state_d = ST_MAC;
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      ST_MAC: begin
        if (i_q == IW'(N_IN - 1)) begin
          i_d     = '0;
          fl_d    = 1'b0;
          state_d = ST_FLUSH;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      ST_FLUSH: begin
        if (fl_q) begin
          fl_d    = 1'b0;
          state_d = ST_FINISH;
        end else begin
          fl_d = 1'b1;
        end
      end
      ST_FINISH: begin
        lane_d  = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (lane_q == last_lane) begin
            lane_d = '0;
            if (last_group) begin
              g_d     = '0;
              state_d = ST_IDLE;
            end else begin
              g_d     = g_q + BA_W'(1);
              state_d = ST_MAC;
            end
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      g_q     <= '0;
      lane_q  <= '0;
      fl_q    <= 1'b0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      g_q     <= g_d;
      lane_q  <= lane_d;
      fl_q    <= fl_d;
      relu_q  <= relu_d;
    end
  end

  // Input vector buffer write port.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && in_valid) in_buf[i_q] <= in_data;
  end

  // Registered buffer read, aligned with the 1-cycle weight memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == ST_MAC);
      if (state_q == ST_MAC) x_q <= in_buf[i_q];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    nn_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear),
      .en_i    (rd_vld_q),
      .x_i     (x_q),
      .w_i     (w_rdata[k*DATA_W +: DATA_W]),
      .acc_o   (acc[k])
    );
  end

  // Bias add, optional ReLU and saturation for every lane.
  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_c    = acc[k] + ACC_W'($signed(b_rdata[k*DATA_W +: DATA_W]));
      res_d[k] = DATA_W'(sat_q(relu_q ? relu(WIDE_W'(sum_c)) : WIDE_W'(sum_c), DATA_W));
    end
  end

  // Result registers captured in FINISH and held while the group drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LANES; k++) res_q[k] <= '0;
    end else if (state_q == ST_FINISH) begin
      for (int unsigned k = 0; k < LANES; k++) res_q[k] <= res_d[k];
    end
  end

endmodule

// File: tb/tb_nn_dense_layer_seq.sv
// Scoreboard bench for nn_dense_layer_seq with a plain-arithmetic reference model.
module tb_nn_dense_layer_seq;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int FRAC   = 16;
  localparam int ACC_W  = 48;
  localparam int G      = (N_OUT + LANES - 1) / LANES;
  localparam int WA_W   = (G * N_IN > 1) ? $clog2(G * N_IN) : 1;
  localparam int BA_W   = (G > 1) ? $clog2(G) : 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    act_relu;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [WA_W-1:0]         w_addr;
  logic [LANES*DATA_W-1:0] w_rdata;
  logic [BA_W-1:0]         b_addr;
  logic [LANES*DATA_W-1:0] b_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;

  nn_dense_layer_seq #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .act_relu  (act_relu),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .b_addr    (b_addr),
    .b_rdata   (b_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0]       xv   [N_IN];
  logic [LANES*DATA_W-1:0] wmem [G*N_IN];
  logic [LANES*DATA_W-1:0] bmem [G];

  logic [32:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          hs_total = 0;
  int          hs_base  = 0;
  int          rdy_mode = 0;
  int          stall_req = 0;

  // External memories with one cycle of read latency.
  always @(posedge clk) begin
    w_rdata <= wmem[w_addr];
    b_rdata <= bmem[b_addr];
    cyc     <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap48(input longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  // Reference: sum of floor-shifted products, wrap, bias, ReLU, clamp to 32 bits.
  function automatic logic [31:0] ref_out(input int n, input bit relu);
    int     g, k;
    longint acc, p;
    g   = n / LANES;
    k   = n % LANES;
    acc = 0;
    for (int i = 0; i < N_IN; i++) begin
      p   = longint'($signed(xv[i])) * longint'($signed(wmem[g*N_IN+i][k*DATA_W +: DATA_W]));
      acc = wrap48(acc + (p >>> FRAC));
    end
    acc = wrap48(acc + longint'($signed(bmem[g][k*DATA_W +: DATA_W])));
    if (relu && acc < 0) acc = 0;
    if (acc > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  function automatic int exp_cycles();
    int t;
    t = N_IN;
    for (int g = 0; g < G; g++)
      t += N_IN + 3 + ((N_OUT - g*LANES < LANES) ? (N_OUT - g*LANES) : LANES);
    return t;
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks held beats stay stable.
  logic        stall_seen = 1'b0;
  logic [32:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({out_last, out_data}), 64'(held));
      end
      if (out_valid && out_ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, required no beat", out_data, out_last);
        end else begin
          check("beat", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        end
      end
      stall_seen = out_valid && !out_ready;
      held       = {out_last, out_data};
    end
  end

  // Downstream ready: 0 always, 1 random, 2 stall stall_req cycles on the second beat.
  initial begin
    int stall_done;
    stall_done = 0;
    out_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 2) stall_done = 0;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && (hs_total - hs_base) == 1 && stall_done < stall_req) begin
            out_ready = 1'b0;
            stall_done++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 1000) begin step(); c++; end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy still 1, required 0 within 1000 cycles");
    end
  endtask

  task automatic start_and_load(input bit relu, input int gap_max);
    bit ok;
    step();
    start    = 1'b1;
    act_relu = relu;
    step();
    start = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = xv[i];
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
      end
      if (!ok) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout: in_ready 0, required 1 for beat %0d", i);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic push_expected(input bit relu);
    for (int n = 0; n < N_OUT; n++)
      exp_q.push_back({(n == N_OUT - 1) ? 1'b1 : 1'b0, ref_out(n, relu)});
  endtask

  task automatic run_vec(input bit relu, input int gap_max, input int bp_mode, input bit noise,
                         input int stall, output int cycles);
    int t0, c;
    wait_idle();
    push_expected(relu);
    hs_base   = hs_total;
    stall_req = stall;
    rdy_mode  = bp_mode;
    step();
    start    = 1'b1;
    act_relu = relu;
    step();
    start = 1'b0;
    t0    = cyc;
    // Loading is inlined after the accepted start so the cycle count is exact.
    for (int i = 0; i < N_IN; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = xv[i];
      c = 0;
      @(negedge clk);
      while (!in_ready && c < 100) begin @(negedge clk); c++; end
      if (!in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout: in_ready 0, required 1 for beat %0d", i);
      end
      step();
    end
    in_valid = 1'b0;
    c = 0;
    while (busy && c < 1000) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      step();
      c++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: busy still 1, required 0");
    end
    cycles = cyc - t0;
    repeat (3) step();
    check("beats_outstanding", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;
  endtask

  task automatic set_basic();
    xv[0] = 32'h0001_0000;
    xv[1] = 32'h0002_0000;
    xv[2] = 32'hFFFF_0000;
    xv[3] = 32'h0000_8000;
    for (int a = 0; a < G*N_IN; a++) wmem[a] = {LANES{32'h0001_0000}};
    for (int g = 0; g < G; g++)      bmem[g] = {LANES{32'h0000_4000}};
  endtask

  function automatic logic [31:0] rnd_q();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) v = $urandom;
    else v = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
    return v;
  endfunction

  initial begin
    int cy;
    rst      = 1'b1;
    start    = 1'b0;
    act_relu = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    set_basic();
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_b_addr", 64'(b_addr), 64'd0);
    rst = 1'b0;
    step();

    // Basic vector at full rate, with exact cycle count.
    set_basic();
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);
    check("cycles_full_rate", 64'(cy), 64'(exp_cycles()));

    // Negative lane-0 weights, with and without ReLU.
    for (int i = 0; i < N_IN; i++) wmem[i][DATA_W-1:0] = 32'hFFFF_0000;
    run_vec(1'b1, 0, 0, 1'b0, 0, cy);
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);

    // Extreme operands: accumulator wrap and both saturation limits.
    for (int i = 0; i < N_IN; i++) xv[i] = 32'h7FFF_FFFF;
    for (int a = 0; a < G*N_IN; a++) wmem[a] = {LANES{32'h7FFF_FFFF}};
    for (int g = 0; g < G; g++) bmem[g] = '0;
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);
    for (int a = 0; a < G*N_IN; a++) wmem[a] = {LANES{32'h8000_0001}};
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);
    for (int i = 1; i < N_IN; i++) xv[i] = '0;
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);
    for (int a = 0; a < G*N_IN; a++) wmem[a] = {LANES{32'h7FFF_FFFF}};
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);

    // Five-cycle stall on the second beat.
    set_basic();
    run_vec(1'b0, 0, 2, 1'b0, 5, cy);
    check("cycles_with_stall", 64'(cy), 64'(exp_cycles() + 5));

    // Reset during the MAC phase of group 1.
    wait_idle();
    push_expected(1'b0);
    hs_base = hs_total;
    start_and_load(1'b0, 0);
    cy = 0;
    while ((hs_total - hs_base) < LANES && cy < 200) begin step(); cy++; end
    check("reached_group1", 64'(hs_total - hs_base), 64'(LANES));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    repeat (15) step();
    run_vec(1'b0, 0, 0, 1'b0, 0, cy);
    check("cycles_after_abort", 64'(cy), 64'(exp_cycles()));

    // Input gaps, stray start/in_valid while busy, random backpressure.
    run_vec(1'b0, 3, 1, 1'b1, 0, cy);

    // Randomized vectors.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N_IN; i++) xv[i] = rnd_q();
      for (int a = 0; a < G*N_IN; a++)
        for (int k = 0; k < LANES; k++) wmem[a][k*DATA_W +: DATA_W] = rnd_q();
      for (int g = 0; g < G; g++)
        for (int k = 0; k < LANES; k++) bmem[g][k*DATA_W +: DATA_W] = rnd_q();
      run_vec(1'($urandom_range(0, 1)), 2, 1, 1'b1, 0, cy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
